// File: rtl/lw.sv
// Single-cycle datapath that executes every fetched instruction as a MIPS lw.
// The fixed instruction ROM and the fixed data ROM feed a 32x32 register file.
// Hierarchical probe nets: OutPC, InstM, OutRegA, SignOut, RDD, DMResult.
module lw (
  input  logic clk,
  input  logic rst,
  input  logic we
);

  logic [31:0] OutPC;
  logic [31:0] pc_d;
  logic [31:0] InstM;
  logic [31:0] OutRegA;
  logic [31:0] SignOut;
  logic [31:0] RDD;
  logic [31:0] DMResult;

  logic [31:0] rf_q [32];

  logic [4:0]  rs;
  logic [4:0]  rt;

  // Opcode/funct are never decoded, and the data ROM ignores the outer address bits.
  logic        unused_bits;
  assign unused_bits = ^{InstM[31:26], RDD[31:8], RDD[1:0]};

  assign rs = InstM[25:21];
  assign rt = InstM[20:16];

  // Next PC: sequential fetch, wrapping modulo 2^32.
  always_comb begin
    pc_d = OutPC + 32'd4;
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      OutPC <= '0;
    end else begin
      OutPC <= pc_d;
    end
  end

  // Instruction ROM, word-indexed. PC bits [1:0] are ignored and fetch wraps every 256 bytes.
  always_comb begin
    InstM = 32'h8C00_0000;
    case (OutPC[7:2])
      6'd0:    InstM = 32'h8C01_0008;
      6'd1:    InstM = 32'h8C22_0004;
      6'd2:    InstM = 32'h8C03_FFFC;
      default: InstM = 32'h8C00_0000;
    endcase
  end

  // Register read port, with R0 hardwired to zero.
  always_comb begin
    OutRegA = '0;
    if (rs != 5'd0) begin
      OutRegA = rf_q[rs];
    end
  end

  // Immediate sign extension and the address adder.
  always_comb begin
    SignOut = {{16{InstM[15]}}, InstM[15:0]};
    RDD     = OutRegA + SignOut;
  end

  // Data ROM where D[k] = 4*k, so the word read is its own in-range byte address.
  always_comb begin
    DMResult = {24'd0, RDD[7:2], 2'b00};
  end

  // Register file write-back. Reset clears every entry and takes priority over we.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we && (rt != 5'd0)) begin
      rf_q[rt] <= DMResult;
    end
  end

endmodule

// File: tb/tb_lw.sv
// Directed testbench for lw. The design's internal nets are probed hierarchically.
module tb_lw;

  logic clk;
  logic rst;
  logic we;

  int checks;
  int errors;

  lw dut (
    .clk (clk),
    .rst (rst),
    .we  (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    we  = 1'b0;

    // Reset state.
    step(1);
    check32("rst_pc",    dut.OutPC,    32'h0000_0000);
    check32("rst_inst",  dut.InstM,    32'h8C01_0008);
    check32("rst_rega",  dut.OutRegA,  32'h0000_0000);
    check32("rst_sign",  dut.SignOut,  32'h0000_0008);
    check32("rst_rdd",   dut.RDD,      32'h0000_0008);
    check32("rst_dm",    dut.DMResult, 32'h0000_0008);
    check32("rst_r1",    dut.rf_q[1],  32'h0000_0000);

    // With we=0 the PC advances and the register file holds.
    rst = 1'b0;
    step(1);
    check32("nw_pc",     dut.OutPC,    32'h0000_0004);
    check32("nw_inst",   dut.InstM,    32'h8C22_0004);
    check32("nw_rega",   dut.OutRegA,  32'h0000_0000);
    check32("nw_sign",   dut.SignOut,  32'h0000_0004);
    check32("nw_rdd",    dut.RDD,      32'h0000_0004);
    check32("nw_dm",     dut.DMResult, 32'h0000_0004);
    check32("nw_r1",     dut.rf_q[1],  32'h0000_0000);

    // Reset again, then run with write-back enabled.
    rst = 1'b1;
    step(1);
    check32("rst2_pc",   dut.OutPC,    32'h0000_0000);
    rst = 1'b0;
    we  = 1'b1;
    step(1);
    check32("w_r1",      dut.rf_q[1],  32'h0000_0008);
    check32("w_pc4",     dut.OutPC,    32'h0000_0004);
    check32("w_rega4",   dut.OutRegA,  32'h0000_0008);
    check32("w_rdd4",    dut.RDD,      32'h0000_000C);
    check32("w_dm4",     dut.DMResult, 32'h0000_000C);
    step(1);
    check32("w_r2",      dut.rf_q[2],  32'h0000_000C);

    // Negative immediate at PC=8.
    check32("neg_pc",    dut.OutPC,    32'h0000_0008);
    check32("neg_sign",  dut.SignOut,  32'hFFFF_FFFC);
    check32("neg_rdd",   dut.RDD,      32'hFFFF_FFFC);
    check32("neg_dm",    dut.DMResult, 32'h0000_00FC);
    step(1);
    check32("neg_r3",    dut.rf_q[3],  32'h0000_00FC);

    // A write targeting R0 at PC=12 is discarded.
    check32("r0_pc",     dut.OutPC,    32'h0000_000C);
    check32("r0_inst",   dut.InstM,    32'h8C00_0000);
    check32("r0_rega",   dut.OutRegA,  32'h0000_0000);
    step(1);
    check32("r0_r0",     dut.rf_q[0],  32'h0000_0000);
    check32("r0_rega2",  dut.OutRegA,  32'h0000_0000);

    // After 64 clocks from reset, fetch wraps back to word 0.
    step(60);
    check32("wrap_pc",   dut.OutPC,    32'h0000_0100);
    check32("wrap_inst", dut.InstM,    32'h8C01_0008);
    check32("wrap_r1",   dut.rf_q[1],  32'h0000_0008);
    check32("wrap_r2",   dut.rf_q[2],  32'h0000_000C);
    check32("wrap_r3",   dut.rf_q[3],  32'h0000_00FC);

    // Mid-run reset wins over a pending write.
    rst = 1'b1;
    step(1);
    check32("mr_pc",     dut.OutPC,    32'h0000_0000);
    check32("mr_r1",     dut.rf_q[1],  32'h0000_0000);
    check32("mr_r2",     dut.rf_q[2],  32'h0000_0000);
    check32("mr_r3",     dut.rf_q[3],  32'h0000_0000);
    check32("mr_inst",   dut.InstM,    32'h8C01_0008);
    check32("mr_dm",     dut.DMResult, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
